// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states,
// ALU operation and PC source selects, and the decoded opcode class.
package cu_pkg;

    localparam logic [3:0] OP_R0  = 4'b0000;
    localparam logic [3:0] OP_R1  = 4'b0001;
    localparam logic [3:0] OP_R2  = 4'b0010;
    localparam logic [3:0] OP_J   = 4'b1000;
    localparam logic [3:0] OP_I0  = 4'b1001;
    localparam logic [3:0] OP_I1  = 4'b1010;
    localparam logic [3:0] OP_I2  = 4'b1011;
    localparam logic [3:0] OP_LW  = 4'b1100;
    localparam logic [3:0] OP_SW  = 4'b1101;
    localparam logic [3:0] OP_BEQ = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] PC_PLUS2  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic ialu;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/cu_opclass.sv
// Combinational opcode classifier: maps a 4-bit opcode to a one-hot class.
import cu_pkg::*;

module cu_opclass (
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R0, OP_R1, OP_R2: cls.rtype   = 1'b1;
            OP_I0, OP_I1, OP_I2: cls.ialu    = 1'b1;
            OP_LW:               cls.lw      = 1'b1;
            OP_SW:               cls.sw      = 1'b1;
            OP_BEQ:              cls.beq     = 1'b1;
            OP_J:                cls.j       = 1'b1;
            default:             cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// Multi-cycle control sequencer: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB, sharing one memory port and the ALU across cycles.
import cu_pkg::*;

module multi_cycle_cu #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       ior_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic       mem_fault,
    output logic [2:0] state
);

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [3:0]         opcode_q;
    logic [3:0]         op_sel;
    op_class_t          cls;
    logic               timeout;

    // The IR is only freshly loaded during DECODE, so classify the live opcode
    // there and the latched copy in every later state.
    assign op_sel = (state_q == S_DECODE) ? opcode : opcode_q;

    cu_opclass u_opclass (
        .opcode (op_sel),
        .cls    (cls)
    );

    // A MemReady arriving on the last allowed cycle completes the access normally.
    assign timeout = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready &&
                     (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            opcode_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q  <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    opcode_q <= opcode;
                    wait_cnt <= '0;
                    state_q  <= cls.illegal ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (cls.rtype || cls.ialu)
                        state_q <= S_WB;
                    else if (cls.lw || cls.sw)
                        state_q <= S_MEM;
                    else
                        state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q  <= cls.lw ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state_q  <= S_FETCH;
                end
                default: begin
                    wait_cnt <= '0;
                    state_q  <= S_FETCH;
                end
            endcase
        end
    end

    // Outputs are decoded from the state because IRWrite, PCWrite and MemFault
    // must react to MemReady and Zero within the same cycle; reset masks them all.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_PLUS2;
        ir_write   = 1'b0;
        ior_d      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        illegal_op = 1'b0;
        mem_fault  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end else begin
                        mem_fault = timeout;
                    end
                end
                S_DECODE: begin
                    illegal_op = cls.illegal;
                end
                S_EXEC: begin
                    if (cls.rtype) begin
                        alu_op = ALU_RFUNCT;
                    end else if (cls.ialu) begin
                        alu_op  = ALU_IFUNCT;
                        alu_src = 1'b1;
                    end else if (cls.lw || cls.sw) begin
                        alu_src = 1'b1;
                    end else if (cls.beq) begin
                        alu_op   = ALU_SUB;
                        pc_write = zero;
                        pc_src   = PC_BRANCH;
                    end else if (cls.j) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                end
                S_MEM: begin
                    ior_d     = 1'b1;
                    mem_read  = cls.lw;
                    mem_write = cls.sw && !cls.lw;
                    mem_fault = timeout;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = cls.rtype;
                    mem_to_reg = cls.lw;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_cu.sv
// Scoreboard bench for multi_cycle_cu: directed per-cycle vectors are queued by
// the stimulus process and compared against the DUT by an independent monitor.
module tb_multi_cycle_cu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, ior_d, mem_read, mem_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src, illegal_op, mem_fault;
    logic [1:0] pc_src, alu_op;
    logic [2:0] state;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [17:0] actual;

    logic [17:0] RST0, F_WAIT, F_DONE, F_FLT, DEC, DEC_ILL;
    logic [17:0] EX_R, EX_I, EX_MEM, EX_BEQ_T, EX_BEQ_N, EX_J;
    logic [17:0] MEM_LD, MEM_ST, MEM_ST_FLT, WB_R, WB_I, WB_LW;

    multi_cycle_cu #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .ior_d      (ior_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .mem_fault  (mem_fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    assign actual = {state, pc_write, pc_src, ir_write, ior_d, mem_read, mem_write,
                     reg_dst, mem_to_reg, reg_write, alu_src, alu_op, illegal_op, mem_fault};

    function automatic logic [17:0] ev(input logic [2:0] st, input logic pcw,
                                       input logic [1:0] pcs, input logic irw,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic asrc, input logic [1:0] aop,
                                       input logic ill, input logic flt);
        return {st, pcw, pcs, irw, iord, mr, mw, rd, m2r, rw, asrc, aop, ill, flt};
    endfunction

    task automatic apply_stimulus(input string name, input logic r, input logic [3:0] op,
                                  input logic rdy, input logic z, input logic [17:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        item.name = name;
        item.v    = e;
        exp_q.push_back(item);
    endtask

    task automatic check_output(input exp_t item);
        n_checks++;
        if (actual === item.v)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", item.name, actual, item.v, $time);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check_output(exp_q.pop_front());
        end
    end

    initial begin
        int guard;
        //              st    pcw  pcs    irw  iord mr   mw   rd   m2r  rw   as   aop    ill  flt
        RST0       = ev(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        F_WAIT     = ev(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        F_DONE     = ev(3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        F_FLT      = ev(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        DEC        = ev(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        DEC_ILL    = ev(3'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        EX_R       = ev(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        EX_I       = ev(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
        EX_MEM     = ev(3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        EX_BEQ_T   = ev(3'd2, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        EX_BEQ_N   = ev(3'd2, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        EX_J       = ev(3'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        MEM_LD     = ev(3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        MEM_ST     = ev(3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        MEM_ST_FLT = ev(3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        WB_R       = ev(3'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        WB_I       = ev(3'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        WB_LW      = ev(3'd4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        apply_stimulus("reset",        1'b1, 4'b0000, 1'b1, 1'b0, RST0);

        // ADD with memory always ready: 4 cycles
        apply_stimulus("add_fetch",    1'b0, 4'b0001, 1'b1, 1'b0, F_DONE);
        apply_stimulus("add_decode",   1'b0, 4'b0001, 1'b1, 1'b0, DEC);
        apply_stimulus("add_exec",     1'b0, 4'b0001, 1'b1, 1'b0, EX_R);
        apply_stimulus("add_wb",       1'b0, 4'b0001, 1'b1, 1'b0, WB_R);

        // LW with MemReady two cycles late in MEM: 7 cycles
        apply_stimulus("lw_fetch",     1'b0, 4'b1100, 1'b1, 1'b0, F_DONE);
        apply_stimulus("lw_decode",    1'b0, 4'b1100, 1'b0, 1'b0, DEC);
        apply_stimulus("lw_exec",      1'b0, 4'b1100, 1'b0, 1'b0, EX_MEM);
        apply_stimulus("lw_mem_w1",    1'b0, 4'b1100, 1'b0, 1'b0, MEM_LD);
        apply_stimulus("lw_mem_w2",    1'b0, 4'b1100, 1'b0, 1'b0, MEM_LD);
        apply_stimulus("lw_mem_done",  1'b0, 4'b1100, 1'b1, 1'b0, MEM_LD);
        apply_stimulus("lw_wb",        1'b0, 4'b1100, 1'b1, 1'b0, WB_LW);

        // BEQ taken, then not taken
        apply_stimulus("beqt_fetch",   1'b0, 4'b1111, 1'b1, 1'b1, F_DONE);
        apply_stimulus("beqt_decode",  1'b0, 4'b1111, 1'b1, 1'b1, DEC);
        apply_stimulus("beqt_exec",    1'b0, 4'b1111, 1'b1, 1'b1, EX_BEQ_T);
        apply_stimulus("beqn_fetch",   1'b0, 4'b1111, 1'b1, 1'b0, F_DONE);
        apply_stimulus("beqn_decode",  1'b0, 4'b1111, 1'b1, 1'b0, DEC);
        apply_stimulus("beqn_exec",    1'b0, 4'b1111, 1'b1, 1'b0, EX_BEQ_N);

        // Jump
        apply_stimulus("j_fetch",      1'b0, 4'b1000, 1'b1, 1'b0, F_DONE);
        apply_stimulus("j_decode",     1'b0, 4'b1000, 1'b1, 1'b0, DEC);
        apply_stimulus("j_exec",       1'b0, 4'b1000, 1'b1, 1'b0, EX_J);

        // Illegal opcodes, including the neighbour of the last R-type code
        apply_stimulus("ill4_fetch",   1'b0, 4'b0100, 1'b1, 1'b0, F_DONE);
        apply_stimulus("ill4_decode",  1'b0, 4'b0100, 1'b1, 1'b0, DEC_ILL);
        apply_stimulus("ill3_fetch",   1'b0, 4'b0011, 1'b1, 1'b0, F_DONE);
        apply_stimulus("ill3_decode",  1'b0, 4'b0011, 1'b1, 1'b0, DEC_ILL);

        // I-ALU
        apply_stimulus("ialu_fetch",   1'b0, 4'b1011, 1'b1, 1'b0, F_DONE);
        apply_stimulus("ialu_decode",  1'b0, 4'b1011, 1'b1, 1'b0, DEC);
        apply_stimulus("ialu_exec",    1'b0, 4'b1011, 1'b1, 1'b0, EX_I);
        apply_stimulus("ialu_wb",      1'b0, 4'b1011, 1'b1, 1'b0, WB_I);

        // SW with MemReady never arriving: fault on the 4th MEM cycle
        apply_stimulus("swto_fetch",   1'b0, 4'b1101, 1'b1, 1'b0, F_DONE);
        apply_stimulus("swto_decode",  1'b0, 4'b1101, 1'b0, 1'b0, DEC);
        apply_stimulus("swto_exec",    1'b0, 4'b1101, 1'b0, 1'b0, EX_MEM);
        apply_stimulus("swto_mem1",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swto_mem2",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swto_mem3",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swto_fault",   1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST_FLT);

        // Fetch timeout straight after, then a fetch that completes
        apply_stimulus("fto_w1",       1'b0, 4'b1101, 1'b0, 1'b0, F_WAIT);
        apply_stimulus("fto_w2",       1'b0, 4'b1101, 1'b0, 1'b0, F_WAIT);
        apply_stimulus("fto_w3",       1'b0, 4'b1101, 1'b0, 1'b0, F_WAIT);
        apply_stimulus("fto_fault",    1'b0, 4'b1101, 1'b0, 1'b0, F_FLT);

        // SW with MemReady on the last allowed cycle: no fault
        apply_stimulus("swok_fetch",   1'b0, 4'b1101, 1'b1, 1'b0, F_DONE);
        apply_stimulus("swok_decode",  1'b0, 4'b1101, 1'b0, 1'b0, DEC);
        apply_stimulus("swok_exec",    1'b0, 4'b1101, 1'b0, 1'b0, EX_MEM);
        apply_stimulus("swok_mem1",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swok_mem2",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swok_mem3",    1'b0, 4'b1101, 1'b0, 1'b0, MEM_ST);
        apply_stimulus("swok_mem4",    1'b0, 4'b1101, 1'b1, 1'b0, MEM_ST);

        // R-type 0000 to cover the lowest R-type code
        apply_stimulus("r0_fetch",     1'b0, 4'b0000, 1'b1, 1'b0, F_DONE);
        apply_stimulus("r0_decode",    1'b0, 4'b0000, 1'b1, 1'b0, DEC);
        apply_stimulus("r0_exec",      1'b0, 4'b0000, 1'b1, 1'b0, EX_R);
        apply_stimulus("r0_wb",        1'b0, 4'b0000, 1'b1, 1'b0, WB_R);

        // Reset during a MEM wait, then recovery
        apply_stimulus("rlw_fetch",    1'b0, 4'b1100, 1'b1, 1'b0, F_DONE);
        apply_stimulus("rlw_decode",   1'b0, 4'b1100, 1'b0, 1'b0, DEC);
        apply_stimulus("rlw_exec",     1'b0, 4'b1100, 1'b0, 1'b0, EX_MEM);
        apply_stimulus("rlw_mem1",     1'b0, 4'b1100, 1'b0, 1'b0, MEM_LD);
        apply_stimulus("rlw_reset",    1'b1, 4'b1100, 1'b0, 1'b0, RST0);
        apply_stimulus("rel_fetch",    1'b0, 4'b1001, 1'b0, 1'b0, F_WAIT);
        apply_stimulus("rel_fetch2",   1'b0, 4'b1001, 1'b1, 1'b0, F_DONE);
        apply_stimulus("rel_decode",   1'b0, 4'b1001, 1'b1, 1'b0, DEC);
        apply_stimulus("rel_exec",     1'b0, 4'b1001, 1'b1, 1'b0, EX_I);
        apply_stimulus("rel_wb",       1'b0, 4'b1001, 1'b1, 1'b0, WB_I);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
